// File: rtl/bask_pkg.sv
// rtl/bask_pkg.sv - shared types and constants for the BASK sampler/modulator path
package bask_pkg;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, PUB} state_t;

    localparam int ADC_BITS         = 8;
    localparam int MIN_FRAME_CYCLES = 9;
    localparam int CLK_HZ           = 1600;

endpackage

// File: rtl/adc_shift_in.sv
// rtl/adc_shift_in.sv - MSB-first serial-in/parallel-out register with async clear
module adc_shift_in
    import bask_pkg::*;
#(
    parameter int WIDTH = ADC_BITS
) (
    input  logic             clk1_6khz,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q;

    // q_next is the word including the bit arriving on this edge, so callers can
    // consume the final bit without an extra cycle of latency.
    assign q_next = {q[WIDTH-2:0], din};

    always_ff @(posedge clk1_6khz or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/adc_serial_sampler.sv
// rtl/adc_serial_sampler.sv - TLC549-style ADC frame sequencer and publisher; option AVG2_EN
module adc_serial_sampler
    import bask_pkg::*;
#(
    parameter int FRAME_CYCLES = 10
) (
    input  logic                clk1_6khz,
    input  logic                rst,
    input  logic                en,
    input  logic                adc_do,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [ADC_BITS-1:0] sampler,
    output logic                Allow
);

    localparam int PAD = FRAME_CYCLES - 1 - ADC_BITS;

    generate
        if (FRAME_CYCLES < MIN_FRAME_CYCLES || FRAME_CYCLES > 255) begin : g_bad_frame
            $error("adc_serial_sampler: FRAME_CYCLES must be within 9..255");
        end
    endgenerate

    state_t              state, state_nx;
    logic [7:0]          cnt;
    logic                sclk_en;
    logic                shift_done;
    logic                pad_done;
    logic [ADC_BITS-1:0] assembled;
    logic [ADC_BITS-1:0] pub_value;

    assign shift_done = (state == SHIFT) && (cnt == 8'(ADC_BITS - 1));
    assign pad_done   = (state == PUB)   && (cnt == 8'(PAD - 1));

    adc_shift_in #(.WIDTH(ADC_BITS)) u_shift_in (
        .clk1_6khz (clk1_6khz),
        .rst       (rst),
        .shift_en  (state == SHIFT),
        .din       (adc_do),
        .q_next    (assembled)
    );

    and u_sclk_gate (adc_sclk, clk1_6khz, sclk_en);

`ifdef AVG2_EN
    logic [ADC_BITS-1:0] prev_byte;
    logic [ADC_BITS:0]   sum;

    assign sum       = {1'b0, assembled} + {1'b0, prev_byte};
    assign pub_value = ADC_BITS'(sum >> 1);

    always_ff @(posedge clk1_6khz or negedge rst) begin
        if (!rst) begin
            prev_byte <= '0;
        end else if (shift_done) begin
            prev_byte <= assembled;
        end
    end
`else
    assign pub_value = assembled;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (en) state_nx = CONV;
            CONV:  state_nx = SHIFT;
            // With the minimum frame there is no pad, so publishing happens on the SHIFT exit.
            SHIFT: if (shift_done) state_nx = (PAD == 0) ? (en ? CONV : IDLE) : PUB;
            PUB:   if (pad_done) state_nx = en ? CONV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1_6khz or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            adc_cs_n <= 1'b1;
            sclk_en  <= 1'b0;
            sampler  <= '0;
            Allow    <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
            adc_cs_n <= (state_nx != SHIFT);
            sclk_en  <= (state_nx == SHIFT);
            Allow    <= !shift_done;
            if (shift_done) begin
                sampler <= pub_value;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_sampler.sv
// tb/tb_adc_serial_sampler.sv - self-checking bench with ADC model and frame-schedule reference
module tb_adc_serial_sampler;

    localparam int F = 10;

    logic       clk1_6khz = 1'b0;
    logic       rst;
    logic       en = 1'b0;
    logic       adc_do = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] sampler;
    logic       Allow;

    adc_serial_sampler #(.FRAME_CYCLES(F)) dut (
        .clk1_6khz (clk1_6khz),
        .rst       (rst),
        .en        (en),
        .adc_do    (adc_do),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .sampler   (sampler),
        .Allow     (Allow)
    );

    always #5 clk1_6khz = ~clk1_6khz;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ADC model: MSB presented when CS falls, next bit presented on the falling
    // clock after each capture edge; noise on adc_do while deselected.
    logic [7:0] byte_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         cap_cnt  = 0;

    always @(negedge adc_cs_n) begin
        cur_byte = (byte_q.size() != 0) ? byte_q.pop_front() : 8'($urandom_range(0, 255));
        cap_cnt  = 0;
        adc_do   = cur_byte[7];
    end

    always @(posedge clk1_6khz) if (adc_cs_n === 1'b0) cap_cnt++;

    always @(negedge clk1_6khz) begin
        if (adc_cs_n === 1'b0 && cap_cnt < 8) adc_do = cur_byte[7 - cap_cnt];
        else adc_do = 1'($urandom);
    end

    // Reference: a frame is a schedule of F cycles measured from its start edge;
    // cycle 0 converts, cycles 1..8 shift, publish on the edge ending cycle 8.
    int         phase = -1;
    logic [7:0] m_sampler = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic       m_allow = 1'b1;

    always @(posedge clk1_6khz) begin
        cyc++;
        if (!rst) begin
            phase = -1; m_sampler = 8'h00; m_prev = 8'h00; m_allow = 1'b1;
        end else begin
            m_allow = 1'b1;
            if (phase == -1) begin
                if (en) phase = 0;
            end else begin
                if (phase == 8) begin
                    m_allow = 1'b0;
`ifdef AVG2_EN
                    m_sampler = 8'((int'(cur_byte) + int'(m_prev)) / 2);
`else
                    m_sampler = cur_byte;
`endif
                    m_prev = cur_byte;
                end
                phase++;
                if (phase == F) phase = en ? 0 : -1;
            end
        end
        #2;
        if (rst) begin
            chk("cyc_cs_n", int'(adc_cs_n), (phase >= 1 && phase <= 8) ? 0 : 1);
            chk("cyc_sclk", int'(adc_sclk), (phase >= 1 && phase <= 8) ? 1 : 0);
            chk("cyc_allow", int'(Allow), int'(m_allow));
            chk("cyc_sampler", int'(sampler), int'(m_sampler));
        end
    end

    int allow_rises = 0;
    always @(posedge Allow) allow_rises++;

    int cs_low_run = 0;
    int last_cs_low = 0;
    always @(posedge clk1_6khz) begin
        #2;
        if (adc_cs_n === 1'b0) cs_low_run++;
        else if (cs_low_run != 0) begin last_cs_low = cs_low_run; cs_low_run = 0; end
    end

    task automatic wait_allow_low(input string nm, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk1_6khz); #3;
            if (Allow === 1'b0) begin at = cyc; break; end
        end
        if (at < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int t, t_prev;
        logic [7:0] exp3 [4];
        exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C; exp3[3] = 8'h81;

        rst = 1'b0;
        repeat (3) @(negedge clk1_6khz);
        rst = 1'b1;
        allow_rises = 0;

        // Idle with en low
        repeat (50) @(posedge clk1_6khz);
        #3;
        chk("t1_allow_edges", allow_rises, 0);
        chk("t1_allow", int'(Allow), 1);
        chk("t1_cs_n", int'(adc_cs_n), 1);
        chk("t1_sampler", int'(sampler), 0);

        // Single frame with 0xA5
        byte_q.push_back(8'hA5);
        @(negedge clk1_6khz); en = 1'b1;
        wait_allow_low("t2", t);
        chk("t2_sampler", int'(sampler), 8'hA5);
        chk("t2_cs_low_len", last_cs_low, 8);
        @(posedge clk1_6khz); #3;
        chk("t2_allow_rise", int'(Allow), 1);

        // Continuous run
        foreach (exp3[i]) byte_q.push_back(exp3[i]);
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_allow_low("t3", t);
            chk("t3_sampler", int'(sampler), int'(exp3[i]));
            if (i > 0) chk("t3_spacing", t - t_prev, F);
            t_prev = t;
        end

        // en dropped during the 3rd shift cycle
        byte_q.push_back(8'hC3);
        repeat (4) @(posedge clk1_6khz);
        #3; en = 1'b0;
        wait_allow_low("t4", t);
        chk("t4_sampler", int'(sampler), 8'hC3);
        repeat (4) @(posedge clk1_6khz);
        #3;
        chk("t4_idle_cs_n", int'(adc_cs_n), 1);
        chk("t4_idle_allow", int'(Allow), 1);
        @(negedge clk1_6khz); en = 1'b1;
        @(posedge clk1_6khz); #3;
        chk("t4_conv_cs_n", int'(adc_cs_n), 1);
        @(posedge clk1_6khz); #3;
        chk("t4_shift_cs_n", int'(adc_cs_n), 0);

        // Reset after 4 captured bits
        repeat (4) @(posedge clk1_6khz);
        #3; rst = 1'b0;
        #1;
        chk("t5_rst_cs_n", int'(adc_cs_n), 1);
        chk("t5_rst_allow", int'(Allow), 1);
        chk("t5_rst_sampler", int'(sampler), 0);
        chk("t5_rst_sclk", int'(adc_sclk), 0);
        byte_q.push_back(8'h5A);
        repeat (2) @(negedge clk1_6khz);
        rst = 1'b1;
        wait_allow_low("t5", t);
        chk("t5_sampler", int'(sampler), 8'h5A);

        // Randomized en activity checked cycle-by-cycle against the reference
        for (int i = 0; i < 600; i++) begin
            @(negedge clk1_6khz);
            if ($urandom_range(0, 15) == 0) en = ~en;
        end
        en = 1'b0;
        repeat (2 * F) @(posedge clk1_6khz);
        #4;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
